// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// and the request legality rule used at acceptance.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Unsigned widths are load-only; halfwords need an even address, words a 4-aligned one.
   function automatic logic req_illegal(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
      logic r;
      case (funct3)
         F3_B:    r = 1'b0;
         F3_H:    r = off[0];
         F3_W:    r = (off != 2'b00);
         F3_BU:   r = we;
         F3_HU:   r = we | off[0];
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: extracts and extends a load from the RAM word, and merges
// sub-word store data into the RAM word for read-modify-write.
module mem_lane
   import mem_pkg::*;
(
   input  logic [31:0] i_rd,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   input  logic [15:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'(i_rd >> {i_off, 3'b000});
      w_half = i_off[1] ? i_rd[31:16] : i_rd[15:0];
      case (i_funct3)
         F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_load = {{16{w_half[15]}}, w_half};
         F3_BU:   o_load = {24'h0, w_byte};
         F3_HU:   o_load = {16'h0, w_half};
         default: o_load = i_rd;
      endcase
   end

   always_comb begin
      o_merge = i_rd;
      if (i_funct3 == F3_B)
         o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      else if (i_funct3 == F3_H)
         o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata;
   end

endmodule

// File: rtl/mem_access.sv
// RV32I load/store unit in front of a 1-cycle synchronous word RAM.
// One request per two cycles: accept in IDLE, respond (and RMW-write) in BUSY.
module mem_access
   import mem_pkg::*;
#(
   parameter int SIZE_LOG2 = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic                 ram_we,
   output logic [SIZE_LOG2-1:0] ram_a,
   output logic [31:0]          ram_wd,
   input  logic [31:0]          ram_rd
);

   state_t               r_state;
   logic [1:0]           r_off;
   logic [2:0]           r_funct3;
   logic                 r_we;
   logic                 r_err;
   logic [15:0]          r_wdata;
   logic [SIZE_LOG2-1:0] r_waddr;

   logic        w_idle;
   logic        w_busy;
   logic        w_accept;
   logic        w_req_err;
   logic        w_rmw;
   logic [31:0] w_load;
   logic [31:0] w_merge;
   logic        w_unused;

   assign w_unused  = ^{req_addr[31:SIZE_LOG2+2]};

   assign w_idle    = (r_state == ST_IDLE);
   // Reset masks BUSY so an interrupted RMW never writes or responds.
   assign w_busy    = (r_state == ST_BUSY) && !rst;
   assign req_ready = w_idle && !rst;
   assign w_accept  = req_valid && req_ready;
   assign w_req_err = req_illegal(req_we, req_funct3, req_addr[1:0]);
   assign w_rmw     = r_we && !r_err && ((r_funct3 == F3_B) || (r_funct3 == F3_H));

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else if (w_idle)
         r_state <= w_accept ? ST_BUSY : ST_IDLE;
      else
         r_state <= ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_off    <= req_addr[1:0];
         r_funct3 <= req_funct3;
         r_we     <= req_we;
         r_err    <= w_req_err;
         r_wdata  <= req_wdata[15:0];
         r_waddr  <= req_addr[SIZE_LOG2+1:2];
      end
   end

   mem_lane u_lane (
      .i_rd     (ram_rd),
      .i_off    (r_off),
      .i_funct3 (r_funct3),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merge  (w_merge)
   );

   always_comb begin
      ram_a  = w_idle ? req_addr[SIZE_LOG2+1:2] : r_waddr;
      ram_we = 1'b0;
      ram_wd = req_wdata;
      if (w_accept && req_we && !w_req_err && (req_funct3 == F3_W)) begin
         ram_we = 1'b1;
      end else if (w_busy && w_rmw) begin
         ram_we = 1'b1;
         ram_wd = w_merge;
      end
   end

   assign rsp_valid = w_busy;
   assign rsp_err   = w_busy && r_err;
   assign rsp_rdata = (w_busy && !r_we && !r_err) ? w_load : 32'h0;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// loads/stores compared against a byte-addressed reference memory.
module tb_mem_access;
   import mem_pkg::*;

   localparam int SL    = 6;
   localparam int DEPTH = 1 << SL;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          ram_we;
   logic [SL-1:0] ram_a;
   logic [31:0]   ram_wd;
   logic [31:0]   ram_rd;

   always #5 clk = ~clk;

   mem_access #(.SIZE_LOG2(SL)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .ram_we     (ram_we),
      .ram_a      (ram_a),
      .ram_wd     (ram_wd),
      .ram_rd     (ram_rd)
   );

   // Word RAM with a bench-side preload port.
   logic [31:0]   ram [DEPTH];
   logic          ld_en = 1'b0;
   logic [SL-1:0] ld_a  = '0;
   logic [31:0]   ld_d  = '0;

   always @(posedge clk) begin
      if (ld_en)       ram[ld_a]  <= ld_d;
      else if (ram_we) ram[ram_a] <= ram_wd;
      ram_rd <= ram[ram_a];
   end

   int we_cnt = 0;
   always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

   logic [7:0] ref_b [4*DEPTH];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      @(negedge clk);
      ld_en = 1'b1;
      ld_a  = SL'(idx);
      ld_d  = v;
      for (int i = 0; i < 4; i++) ref_b[4*idx+i] = 8'(v >> (8*i));
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Reference behaviour from the RV32I rules, on a byte-addressed memory.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int nwr);
      int size, base;
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      err  = (size == 0) || (we && f3 > 3'd3) || ((addr % size) != 0);
      base = int'((addr >> 2) % DEPTH) * 4 + int'(addr[1:0]);
      rd   = 32'h0;
      nwr  = 0;
      if (!err && !we) begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_b[base+i]) << (8*i));
         if (f3 < 3'd4 && size < 4 && v[8*size-1])
            v = v | ~((32'd1 << (8*size)) - 32'd1);
         rd = v;
      end else if (!err && we) begin
         for (int i = 0; i < size; i++) ref_b[base+i] = 8'(wd >> (8*i));
         nwr = 1;
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge in IDLE.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag, output logic [31:0] got_rd);
      int t, c0, nwr;
      logic e_err;
      logic [31:0] e_rd;
      t = 0;
      while (!req_ready && t < 10) begin
         @(negedge clk); #1;
         t++;
      end
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_idle_we"}, 32'(ram_we), 32'd0);
      c0 = we_cnt;
      model(we, f3, addr, wd, e_err, e_rd, nwr);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(e_err));
      chk({tag, "_rdata"}, rsp_rdata, e_rd);
      chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
      got_rd = rsp_rdata;
      @(negedge clk); #1;
      chk({tag, "_we_cycles"}, 32'(we_cnt - c0), 32'(nwr));
      chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        e_err;
      logic [31:0] e_rd;
      int          nwr, c0, pulses;
      logic [31:0] sw_data [4];

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < DEPTH; i++) set_word(i, (i == 5) ? 32'h8899AABB : $urandom);
      @(negedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      do_req(1'b0, F3_B,  32'h15, 32'h0, "lb", rd);   chk("lb_value", rd, 32'hFFFFFFAA);
      do_req(1'b0, F3_HU, 32'h16, 32'h0, "lhu", rd);  chk("lhu_value", rd, 32'h00008899);
      do_req(1'b0, F3_H,  32'h16, 32'h0, "lh", rd);   chk("lh_value", rd, 32'hFFFF8899);
      do_req(1'b1, F3_B,  32'h15, 32'h123456CC, "sb", rd);
      do_req(1'b0, F3_W,  32'h14, 32'h0, "lw_merged", rd); chk("lw_merged_value", rd, 32'h8899CCBB);
      do_req(1'b0, F3_W,  32'h22, 32'h0, "lw_mis", rd);
      do_req(1'b1, F3_H,  32'h23, 32'hFFFF, "sh_mis", rd);

      // Reset while BUSY must abort the pending RMW.
      c0 = we_cnt;
      req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h14; req_wdata = 32'h5A5A5A5A;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0;
      #1;
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_ram_we", 32'(ram_we), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_we_cycles", 32'(we_cnt - c0), 32'd0);
      do_req(1'b0, F3_W, 32'h14, 32'h0, "abort_lw", rd); chk("abort_word", rd, 32'h8899CCBB);

      // Continuous request stream of four word stores.
      c0 = we_cnt;
      pulses = 0;
      for (int k = 0; k < 4; k++) sw_data[k] = $urandom;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc % 2 == 0) begin
            req_we = 1'b1; req_funct3 = F3_W;
            req_addr = 32'((40 + cyc/2) * 4); req_wdata = sw_data[cyc/2];
            model(1'b1, F3_W, req_addr, req_wdata, e_err, e_rd, nwr);
         end
         req_valid = 1'b1;
         #1;
         chk("stream_ready", 32'(req_ready), (cyc % 2 == 0) ? 32'd1 : 32'd0);
         if (rsp_valid) pulses++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("stream_pulses", 32'(pulses), 32'd4);
      chk("stream_we_cycles", 32'(we_cnt - c0), 32'd4);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand", rd);
      end

      for (int i = 0; i < DEPTH; i++)
         chk("final_word", ram[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter SIZE_LOG2, default 13, meaning log2 of RAM depth in 32-bit words.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port req_valid  in  1  a load/store request is present.
REQ-005 SHALL have port req_ready  out  1  block can accept; transfer when req_valid && req_ready at a rising edge.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  out  32  load result, extended; 0 when rsp_valid low or for stores.
REQ-012 SHALL have port rsp_err  out  1  with rsp_valid: misaligned or illegal request.
REQ-013 SHALL have ports ram_we out 1, ram_a out SIZE_LOG2, ram_wd out 32, ram_rd in 32  to the word RAM (1-cycle synchronous read, write on WE at edge).

Function
REQ-014 SHALL implement two states: IDLE (req_ready=1) and BUSY (req_ready=0); IDLE->BUSY on acceptance, BUSY->IDLE unconditionally.
REQ-015 SHALL drive ram_a = req_addr[SIZE_LOG2+1:2] in IDLE and the latched word address in BUSY; upper address bits ignored (wrap).
REQ-016 SHALL latch addr[1:0], funct3, we, wdata, word address on acceptance.
REQ-017 SHALL assert rsp_valid exactly in the BUSY cycle following acceptance (latency 1, throughput 1 request per 2 cycles).
REQ-018 Loads SHALL return ram_rd lane selected by latched addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word, combinationally during BUSY.
REQ-019 SW SHALL write req_wdata with ram_we=1 combinationally in the accepting IDLE cycle.
REQ-020 SB/SH SHALL read-modify-write: read issued at acceptance; in BUSY ram_we=1, ram_wd = ram_rd with addressed byte/halfword replaced by wdata[7:0]/[15:0].
REQ-021 Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) or illegal funct3 (011,110,111; stores 100,101) SHALL complete with rsp_err=1, rsp_rdata=0, no RAM write.
REQ-022 ram_we SHALL be 0 in every other case, including IDLE without acceptance.
REQ-023 Back-to-back SB then LW same word SHALL return the merged data (write lands before next read).

Reset
REQ-024 While rst high: state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_we=0, req_ready=0.
REQ-025 Reset during BUSY SHALL abort the operation: no RMW write, no rsp_valid; latched fields need no reset.

Structure
REQ-026 SHALL place funct3 width codes and the state enum in shared package mem_pkg.
REQ-027 SHALL factor lane extraction and store merge into one combinational sub-module mem_lane.

Verification
REQ-028 Mem word 5 = 0x8899AABB; LB addr 0x15 -> rsp_valid next cycle, rsp_rdata 0xFFFFFFAA, rsp_err 0.
REQ-029 Same word; LHU addr 0x16 -> rsp_rdata 0x00008899; LH -> 0xFFFF8899.
REQ-030 SB addr 0x15 wdata 0x123456CC then LW addr 0x14 -> 0x8899CCBB; exactly one ram_we cycle for the SB.
REQ-031 LW addr 0x22 -> rsp_err 1, rsp_rdata 0; SH addr 0x23 -> rsp_err 1, no ram_we.
REQ-032 SH addr 0x14 accepted, rst asserted in BUSY cycle -> ram_we stays 0, word unchanged, rsp_valid 0.
REQ-033 Continuous req_valid with 4 SW -> req_ready alternates 1/0, four rsp_valid pulses, all words written.
